// File: rtl/vanilla_long_op_ctrl.sv
// -----------------------------------------------------------------------------
// vanilla_long_op_ctrl
//
// Front-end controller for a shared iterative divide/square-root unit.  Integer
// div/rem requests and FP fdiv/fsqrt requests compete for the one unit; at most
// one operation is in flight.  The controller arbitrates (alternating on ties),
// issues the operation, collects the result and hands it back on the writeback
// port of the side that asked for it.  While an operation is outstanding the
// owner side reports busy plus its destination register for hazard checks.
//
// Ports
//   clk_i, reset_i            clock, synchronous active-high reset
//   int_v_i / int_ready_o     integer request: int_op_i (0 DIV,1 DIVU,2 REM,3 REMU),
//                             int_rs1_i, int_rs2_i, int_rd_i
//   fp_v_i / fp_ready_o       FP request: fp_is_sqrt_i, fp_rs1_i, fp_rs2_i, fp_rd_i
//   unit_v_o / unit_ready_i   issue to unit: unit_op_o = {is_fp, op[1:0]},
//                             unit_a_o, unit_b_o
//   unit_v_i / unit_yumi_o    result from unit: unit_data_i
//   int_wb_*, fp_wb_*         writeback valid/yumi, rd, data per side
//   int_busy_*, fp_busy_*     owner busy flag and destination register
// -----------------------------------------------------------------------------
module vanilla_long_op_ctrl #(
   parameter int data_width_p     = 32,
   parameter int reg_addr_width_p = 5
) (
   input  logic                        clk_i,
   input  logic                        reset_i,

   input  logic                        int_v_i,
   output logic                        int_ready_o,
   input  logic [1:0]                  int_op_i,
   input  logic [data_width_p-1:0]     int_rs1_i,
   input  logic [data_width_p-1:0]     int_rs2_i,
   input  logic [reg_addr_width_p-1:0] int_rd_i,

   input  logic                        fp_v_i,
   output logic                        fp_ready_o,
   input  logic                        fp_is_sqrt_i,
   input  logic [data_width_p-1:0]     fp_rs1_i,
   input  logic [data_width_p-1:0]     fp_rs2_i,
   input  logic [reg_addr_width_p-1:0] fp_rd_i,

   output logic                        unit_v_o,
   input  logic                        unit_ready_i,
   output logic [2:0]                  unit_op_o,
   output logic [data_width_p-1:0]     unit_a_o,
   output logic [data_width_p-1:0]     unit_b_o,

   input  logic                        unit_v_i,
   output logic                        unit_yumi_o,
   input  logic [data_width_p-1:0]     unit_data_i,

   output logic                        int_wb_v_o,
   input  logic                        int_wb_yumi_i,
   output logic [reg_addr_width_p-1:0] int_wb_rd_o,
   output logic [data_width_p-1:0]     int_wb_data_o,

   output logic                        fp_wb_v_o,
   input  logic                        fp_wb_yumi_i,
   output logic [reg_addr_width_p-1:0] fp_wb_rd_o,
   output logic [data_width_p-1:0]     fp_wb_data_o,

   output logic                        int_busy_o,
   output logic [reg_addr_width_p-1:0] int_busy_rd_o,
   output logic                        fp_busy_o,
   output logic [reg_addr_width_p-1:0] fp_busy_rd_o
);

   localparam logic [1:0] state_idle  = 2'd0;
   localparam logic [1:0] state_issue = 2'd1;
   localparam logic [1:0] state_busy  = 2'd2;
   localparam logic [1:0] state_wb    = 2'd3;

   logic [1:0]                  state_reg, state_next;
   logic                        last_grant_fp_reg;
   logic                        post_reset_reg;
   logic                        is_fp_reg;
   logic [1:0]                  op_reg;
   logic [reg_addr_width_p-1:0] rd_reg;
   logic [data_width_p-1:0]     a_reg, b_reg, result_reg;

   logic active, can_grant, sel_int, sel_fp, grant, owner_yumi;
   logic in_issue, in_busy, in_wb, busy_any;

   // Every output is forced quiet while reset is held, independent of the
   // (not yet reset) register contents.
   assign active = ~reset_i;

   // The cycle right after reset is kept idle-quiet as well: no grant there.
   assign can_grant = active & (state_reg == state_idle) & ~post_reset_reg;

   // Sole requester wins; on a tie the side not granted last wins.
   assign sel_int = int_v_i & (~fp_v_i | last_grant_fp_reg);
   assign sel_fp  = fp_v_i & (~int_v_i | ~last_grant_fp_reg);
   assign grant   = can_grant & (sel_int | sel_fp);

   assign owner_yumi = is_fp_reg ? fp_wb_yumi_i : int_wb_yumi_i;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         state_idle:  if (grant)        state_next = state_issue;
         state_issue: if (unit_ready_i) state_next = state_busy;
         state_busy:  if (unit_v_i)     state_next = state_wb;
         state_wb:    if (owner_yumi)   state_next = state_idle;
         default:                       state_next = state_idle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_reg         <= state_idle;
         last_grant_fp_reg <= 1'b1;
         post_reset_reg    <= 1'b1;
         is_fp_reg         <= 1'b0;
         op_reg            <= '0;
         rd_reg            <= '0;
         a_reg             <= '0;
         b_reg             <= '0;
         result_reg        <= '0;
      end else begin
         state_reg      <= state_next;
         post_reset_reg <= 1'b0;
         if (grant) begin
            last_grant_fp_reg <= sel_fp;
            is_fp_reg         <= sel_fp;
            if (sel_fp) begin
               op_reg <= {1'b0, fp_is_sqrt_i};
               rd_reg <= fp_rd_i;
               a_reg  <= fp_rs1_i;
               // sqrt has a single operand; the second is presented as zero
               b_reg  <= fp_is_sqrt_i ? '0 : fp_rs2_i;
            end else begin
               op_reg <= int_op_i;
               rd_reg <= int_rd_i;
               a_reg  <= int_rs1_i;
               b_reg  <= int_rs2_i;
            end
         end
         if ((state_reg == state_busy) && unit_v_i)
            result_reg <= unit_data_i;
      end
   end

   assign in_issue = active & (state_reg == state_issue);
   assign in_busy  = active & (state_reg == state_busy);
   assign in_wb    = active & (state_reg == state_wb);
   assign busy_any = active & (state_reg != state_idle);

   assign int_ready_o = can_grant & sel_int;
   assign fp_ready_o  = can_grant & sel_fp;

   assign unit_v_o  = in_issue;
   assign unit_op_o = in_issue ? {is_fp_reg, op_reg} : 3'b000;
   assign unit_a_o  = in_issue ? a_reg : '0;
   assign unit_b_o  = in_issue ? b_reg : '0;

   assign unit_yumi_o = in_busy & unit_v_i;

   assign int_wb_v_o    = in_wb & ~is_fp_reg;
   assign int_wb_rd_o   = int_wb_v_o ? rd_reg : '0;
   assign int_wb_data_o = int_wb_v_o ? result_reg : '0;
   assign fp_wb_v_o     = in_wb & is_fp_reg;
   assign fp_wb_rd_o    = fp_wb_v_o ? rd_reg : '0;
   assign fp_wb_data_o  = fp_wb_v_o ? result_reg : '0;

   assign int_busy_o    = busy_any & ~is_fp_reg;
   assign int_busy_rd_o = int_busy_o ? rd_reg : '0;
   assign fp_busy_o     = busy_any & is_fp_reg;
   assign fp_busy_rd_o  = fp_busy_o ? rd_reg : '0;

endmodule

// File: tb/tb_vanilla_long_op_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vanilla_long_op_ctrl
// Directed bench for vanilla_long_op_ctrl.  The shared unit is emulated by
// driving unit_ready_i / unit_v_i / unit_data_i directly from the sequence.
// -----------------------------------------------------------------------------
module tb_vanilla_long_op_ctrl;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        int_v_i, int_ready_o;
   logic [1:0]  int_op_i;
   logic [31:0] int_rs1_i, int_rs2_i;
   logic [4:0]  int_rd_i;
   logic        fp_v_i, fp_ready_o, fp_is_sqrt_i;
   logic [31:0] fp_rs1_i, fp_rs2_i;
   logic [4:0]  fp_rd_i;
   logic        unit_v_o, unit_ready_i;
   logic [2:0]  unit_op_o;
   logic [31:0] unit_a_o, unit_b_o;
   logic        unit_v_i, unit_yumi_o;
   logic [31:0] unit_data_i;
   logic        int_wb_v_o, int_wb_yumi_i;
   logic [4:0]  int_wb_rd_o;
   logic [31:0] int_wb_data_o;
   logic        fp_wb_v_o, fp_wb_yumi_i;
   logic [4:0]  fp_wb_rd_o;
   logic [31:0] fp_wb_data_o;
   logic        int_busy_o, fp_busy_o;
   logic [4:0]  int_busy_rd_o, fp_busy_rd_o;

   int assertions = 0;
   int failures   = 0;

   always #5 clk_i = ~clk_i;

   vanilla_long_op_ctrl #(.data_width_p(32), .reg_addr_width_p(5)) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .int_v_i(int_v_i), .int_ready_o(int_ready_o), .int_op_i(int_op_i),
      .int_rs1_i(int_rs1_i), .int_rs2_i(int_rs2_i), .int_rd_i(int_rd_i),
      .fp_v_i(fp_v_i), .fp_ready_o(fp_ready_o), .fp_is_sqrt_i(fp_is_sqrt_i),
      .fp_rs1_i(fp_rs1_i), .fp_rs2_i(fp_rs2_i), .fp_rd_i(fp_rd_i),
      .unit_v_o(unit_v_o), .unit_ready_i(unit_ready_i), .unit_op_o(unit_op_o),
      .unit_a_o(unit_a_o), .unit_b_o(unit_b_o),
      .unit_v_i(unit_v_i), .unit_yumi_o(unit_yumi_o), .unit_data_i(unit_data_i),
      .int_wb_v_o(int_wb_v_o), .int_wb_yumi_i(int_wb_yumi_i),
      .int_wb_rd_o(int_wb_rd_o), .int_wb_data_o(int_wb_data_o),
      .fp_wb_v_o(fp_wb_v_o), .fp_wb_yumi_i(fp_wb_yumi_i),
      .fp_wb_rd_o(fp_wb_rd_o), .fp_wb_data_o(fp_wb_data_o),
      .int_busy_o(int_busy_o), .int_busy_rd_o(int_busy_rd_o),
      .fp_busy_o(fp_busy_o), .fp_busy_rd_o(fp_busy_rd_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assertions++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // advance one clock; leave 1 time unit after the edge before touching anything
   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   // checks every output is quiet
   task automatic check_quiet(input string tag);
      check({tag, " ready"}, 32'({int_ready_o, fp_ready_o}), 0);
      check({tag, " unit"}, 32'({unit_v_o, unit_yumi_o, unit_op_o}), 0);
      check({tag, " unit_ab"}, unit_a_o | unit_b_o, 0);
      check({tag, " wb_v"}, 32'({int_wb_v_o, fp_wb_v_o}), 0);
      check({tag, " wb_data"}, int_wb_data_o | fp_wb_data_o, 0);
      check({tag, " wb_rd"}, 32'(int_wb_rd_o | fp_wb_rd_o), 0);
      check({tag, " busy"}, 32'({int_busy_o, fp_busy_o}), 0);
      check({tag, " busy_rd"}, 32'(int_busy_rd_o | fp_busy_rd_o), 0);
   endtask

   // Full operation with a unit that is always ready and answers the cycle
   // after issue.  Called in IDLE with the request already driven and settled.
   task automatic run_op(input logic exp_fp, input logic [31:0] exp_op,
                         input logic [31:0] exp_a, input logic [31:0] exp_b,
                         input logic [31:0] exp_rd, input logic [31:0] res,
                         input string tag);
      check({tag, " own_ready"}, 32'(exp_fp ? fp_ready_o : int_ready_o), 1);
      check({tag, " oth_ready"}, 32'(exp_fp ? int_ready_o : fp_ready_o), 0);
      cyc();                               // grant edge -> ISSUE
      unit_ready_i = 1'b1;
      #1;
      check({tag, " unit_v"}, 32'(unit_v_o), 1);
      check({tag, " unit_op"}, 32'(unit_op_o), exp_op);
      check({tag, " unit_a"}, unit_a_o, exp_a);
      check({tag, " unit_b"}, unit_b_o, exp_b);
      check({tag, " busy"}, 32'(exp_fp ? fp_busy_o : int_busy_o), 1);
      check({tag, " busy_rd"}, 32'(exp_fp ? fp_busy_rd_o : int_busy_rd_o), exp_rd);
      cyc();                               // -> BUSY
      unit_v_i    = 1'b1;
      unit_data_i = res;
      #1;
      check({tag, " unit_yumi"}, 32'(unit_yumi_o), 1);
      check({tag, " busy_rd2"}, 32'(exp_fp ? fp_busy_rd_o : int_busy_rd_o), exp_rd);
      cyc();                               // -> WB, 3 cycles after grant
      unit_v_i = 1'b0;
      #1;
      check({tag, " wb_v"}, 32'(exp_fp ? fp_wb_v_o : int_wb_v_o), 1);
      check({tag, " oth_wb_v"}, 32'(exp_fp ? int_wb_v_o : fp_wb_v_o), 0);
      check({tag, " wb_rd"}, 32'(exp_fp ? fp_wb_rd_o : int_wb_rd_o), exp_rd);
      check({tag, " wb_data"}, exp_fp ? fp_wb_data_o : int_wb_data_o, res);
      if (exp_fp) fp_wb_yumi_i = 1'b1; else int_wb_yumi_i = 1'b1;
      #1;
      check({tag, " no_grant_yumi"}, 32'({int_ready_o, fp_ready_o}), 0);
      check({tag, " busy_yumi"}, 32'(exp_fp ? fp_busy_o : int_busy_o), 1);
      cyc();                               // -> IDLE
      fp_wb_yumi_i  = 1'b0;
      int_wb_yumi_i = 1'b0;
      #1;
      check({tag, " done_busy"}, 32'({int_busy_o, fp_busy_o}), 0);
      $display("op %s done: fp=%0d op=%0d rd=%0d result=0x%0h", tag, exp_fp, exp_op, exp_rd, res);
   endtask

   initial begin
      reset_i = 1'b1;
      int_v_i = 0; int_op_i = 0; int_rs1_i = 0; int_rs2_i = 0; int_rd_i = 0;
      fp_v_i = 0; fp_is_sqrt_i = 0; fp_rs1_i = 0; fp_rs2_i = 0; fp_rd_i = 0;
      unit_ready_i = 0; unit_v_i = 0; unit_data_i = 0;
      int_wb_yumi_i = 0; fp_wb_yumi_i = 0;

      // ---- reset ----
      cyc();
      int_v_i = 1'b1;                      // request during reset must not be seen
      #1;
      check_quiet("in_reset");
      cyc();
      reset_i = 1'b0;
      #1;
      check_quiet("post_reset");
      $display("reset: outputs quiet during and after reset");

      // ---- tie: INT, FP, INT, FP ----
      int_v_i = 1; int_op_i = 2'd1; int_rs1_i = 50; int_rs2_i = 6; int_rd_i = 7;
      fp_v_i = 1; fp_is_sqrt_i = 1; fp_rs1_i = 32'h3F800000; fp_rs2_i = 32'h12345678; fp_rd_i = 9;
      cyc();
      run_op(0, 1, 50, 6, 7, 8, "tie0");
      run_op(1, 5, 32'h3F800000, 0, 9, 32'h3F800000, "tie1");
      run_op(0, 1, 50, 6, 7, 8, "tie2");
      run_op(1, 5, 32'h3F800000, 0, 9, 32'h3F800000, "tie3");
      int_v_i = 0; fp_v_i = 0;
      #1;

      // ---- single integer REM ----
      int_v_i = 1; int_op_i = 2'd2; int_rs1_i = 17; int_rs2_i = 5; int_rd_i = 3;
      #1;
      run_op(0, 2, 17, 5, 3, 2, "rem");
      int_v_i = 0;
      #1;
      check("rem idle busy_rd", 32'(int_busy_rd_o), 0);

      // ---- backpressure ----
      int_v_i = 1; int_op_i = 2'd0; int_rs1_i = 100; int_rs2_i = 7; int_rd_i = 4;
      unit_ready_i = 0;
      #1;
      check("bp grant", 32'(int_ready_o), 1);
      cyc();
      int_v_i = 0; int_rs1_i = 1; int_rs2_i = 1; int_rd_i = 1;   // must not leak in
      fp_v_i = 1; fp_is_sqrt_i = 0; fp_rs1_i = 11; fp_rs2_i = 22; fp_rd_i = 20;
      #1;
      for (int i = 0; i < 6; i++) begin
         if (i == 5) begin unit_ready_i = 1; #1; end
         check("bp unit_v", 32'(unit_v_o), 1);
         check("bp unit_op", 32'(unit_op_o), 0);
         check("bp unit_a", unit_a_o, 100);
         check("bp unit_b", unit_b_o, 7);
         check("bp fp_ready", 32'(fp_ready_o), 0);
         $display("bp issue cycle %0d: unit_v=%0d ready=%0d", i, unit_v_o, unit_ready_i);
         cyc();
      end
      unit_v_i = 1; unit_data_i = 14;
      cyc();
      unit_v_i = 0;
      #1;
      for (int i = 0; i < 3; i++) begin
         check("bp wb_v", 32'(int_wb_v_o), 1);
         check("bp wb_data", int_wb_data_o, 14);
         check("bp wb_rd", 32'(int_wb_rd_o), 4);
         check("bp fp_ready_wb", 32'(fp_ready_o), 0);
         $display("bp wb stall cycle %0d: wb_v=%0d data=%0d", i, int_wb_v_o, int_wb_data_o);
         cyc();
      end
      int_wb_yumi_i = 1; fp_v_i = 0;
      #1;
      check("bp wb_v_yumi", 32'(int_wb_v_o), 1);
      cyc();
      int_wb_yumi_i = 0;
      #1;
      check("bp after wb_v", 32'(int_wb_v_o), 0);
      check("bp after busy", 32'(int_busy_o), 0);

      // ---- FSQRT ----
      fp_v_i = 1; fp_is_sqrt_i = 1; fp_rs1_i = 32'h40800000; fp_rs2_i = 32'hFFFFFFFF; fp_rd_i = 12;
      #1;
      run_op(1, 5, 32'h40800000, 0, 12, 32'h40000000, "fsqrt");
      fp_v_i = 0;
      #1;

      // ---- misdirected yumi ----
      fp_wb_yumi_i = 1;
      #1;
      check_quiet("mis idle");
      cyc();
      fp_wb_yumi_i = 0;
      int_v_i = 1; int_op_i = 2'd3; int_rs1_i = 9; int_rs2_i = 4; int_rd_i = 6;
      #1;
      check("mis grant", 32'(int_ready_o), 1);
      cyc();
      int_v_i = 0; unit_ready_i = 1;
      #1;
      check("mis unit_op", 32'(unit_op_o), 3);
      cyc();
      unit_v_i = 1; unit_data_i = 1;
      cyc();
      unit_v_i = 0; fp_wb_yumi_i = 1;
      #1;
      check("mis wb_v", 32'(int_wb_v_o), 1);
      cyc();
      fp_wb_yumi_i = 0;
      #1;
      check("mis wb_v held", 32'(int_wb_v_o), 1);
      check("mis wb_data", int_wb_data_o, 1);
      check("mis wb_rd", 32'(int_wb_rd_o), 6);
      check("mis fp_wb_v", 32'(fp_wb_v_o), 0);
      $display("misdirected yumi ignored: int_wb_v=%0d", int_wb_v_o);
      int_wb_yumi_i = 1;
      cyc();
      int_wb_yumi_i = 0;
      #1;
      check("mis released", 32'(int_wb_v_o), 0);

      // ---- reset in BUSY ----
      int_v_i = 1; int_op_i = 2'd1; int_rs1_i = 40; int_rs2_i = 8; int_rd_i = 5;
      #1;
      check("rst grant", 32'(int_ready_o), 1);
      cyc();
      int_v_i = 0; unit_ready_i = 1;
      cyc();                               // now BUSY, unit has not answered
      #1;
      check("rst pre busy", 32'(int_busy_o), 1);
      reset_i = 1;
      #1;
      check_quiet("rst during");
      cyc();
      reset_i = 0;
      int_v_i = 1; int_op_i = 2'd0; int_rs1_i = 60; int_rs2_i = 3; int_rd_i = 2;
      fp_v_i = 1; fp_is_sqrt_i = 0; fp_rs1_i = 5; fp_rs2_i = 6; fp_rd_i = 8;
      #1;
      check_quiet("rst after");
      $display("reset in BUSY: operation abandoned");
      cyc();
      run_op(0, 0, 60, 3, 2, 20, "post_rst");   // tie goes to INT: last_grant back to FP
      int_v_i = 0; fp_v_i = 0;
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule

// File: doc/vanilla_long_op_ctrl.md
VANILLA_LONG_OP_CTRL -- requirements
Module: vanilla_long_op_ctrl

Interface
REQ-001 Parameter data_width_p, default 32, operand/result width.
REQ-002 Parameter reg_addr_width_p, default 5, destination register address width.
REQ-003 clk_i  in  1  clock; single clock domain.
REQ-004 reset_i  in  1  reset; synchronous, active-high.
REQ-005 int_v_i / int_ready_o  in/out  1  integer div/rem request valid/ready; op int_op_i[1:0] (0=DIV, 1=DIVU, 2=REM, 3=REMU); operands int_rs1_i, int_rs2_i [data_width_p]; destination int_rd_i [reg_addr_width_p].
REQ-006 fp_v_i / fp_ready_o  in/out  1  FP request valid/ready; fp_is_sqrt_i 1 (0=FDIV, 1=FSQRT); operands fp_rs1_i, fp_rs2_i [data_width_p]; destination fp_rd_i [reg_addr_width_p].
REQ-007 unit_v_o / unit_ready_i  out/in  1  issue handshake to the shared iterative div/sqrt unit; unit_op_o[2:0] = {is_fp, op[1:0]}, where FP op is 0=div, 1=sqrt; operands unit_a_o, unit_b_o [data_width_p].
REQ-008 unit_v_i / unit_yumi_o  in/out  1  result handshake from the unit; result data unit_data_i [data_width_p].
REQ-009 int_wb_v_o / int_wb_yumi_i  out/in  1  integer writeback; int_wb_rd_o, int_wb_data_o. The FP writeback uses the identical fp_wb_* set of ports.
REQ-010 int_busy_o, int_busy_rd_o, fp_busy_o, fp_busy_rd_o  out  hazard reporting: owner side is busy with the given destination register.

Function
REQ-011 Exactly one operation SHALL be outstanding at a time; the FSM states are IDLE, ISSUE, BUSY and WB.
REQ-012 Both ready outputs SHALL be 0 outside IDLE; in IDLE, int_ready_o and fp_ready_o SHALL be asserted only for the side the arbiter selects.
REQ-013 Arbitration in IDLE SHALL work as follows:
- a sole requester wins;
- when both sides request, the side not granted last wins;
- last_grant resets to FP, so integer wins the first tie.
REQ-014 On grant (v & ready) the block SHALL:
- register op, rd, operands and owner;
- update last_grant;
- go IDLE->ISSUE.
REQ-015 ISSUE: unit_v_o=1 with the registered op and operands, held stable until unit_ready_i; the cycle unit_v_o & unit_ready_i SHALL go ISSUE->BUSY.
REQ-016 For an FSQRT request, unit_b_o SHALL be driven as 0.
REQ-017 BUSY: unit_yumi_o = unit_v_i. On unit_v_i the block SHALL latch unit_data_i into the result register and go BUSY->WB; unit_yumi_o SHALL be 0 in every other state.
REQ-018 WB: the owner's wb_v_o=1 with the registered rd and result; the other side's wb_v_o=0. On the owner's wb_yumi_i the block SHALL go WB->IDLE; data and rd SHALL stay stable until yumi.
REQ-019 A wb_yumi_i arriving outside WB, or on the non-owner side, SHALL be ignored.
REQ-020 The owner's busy_o SHALL be 1 from the cycle after grant through the WB yumi cycle inclusive; busy_rd_o equals the registered rd while busy_o, else 0.
REQ-021 No new grant SHALL occur in the WB yumi cycle. Minimum cadence is grant, ISSUE, BUSY, WB = 4 cycles with unit_ready_i=1 and unit_v_i returning the cycle after issue.
REQ-022 Requests SHALL not be queued. A requester whose v is dropped before grant leaves no state behind.
REQ-023 Op encoding passes through unmodified. Divide-by-zero and overflow results are the unit's responsibility.

Reset
REQ-024 During reset_i, and in the first cycle after it, state SHALL be IDLE, last_grant SHALL be FP, and all outputs (ready, v, yumi, busy, rd, data) SHALL be 0.
REQ-025 Reset asserted in any state SHALL abandon the in-flight operation with no writeback. The shared unit SHALL be reset by the same reset_i, so no stale unit_v_i appears afterwards.

Verification
REQ-026 Single integer op: int_v_i=1, op=2 (REM), rs1=17, rs2=5, rd=3; unit returns 2 the cycle after issue. Required: int_wb_v_o on cycle 3 after grant with rd=3, data=2; int_busy_rd_o=3 throughout.
REQ-027 Tie: int and fp request every cycle for 4 ops. Required grant order INT, FP, INT, FP; unit_op_o values 3'b0xx then 3'b10x.
REQ-028 Backpressure: unit_ready_i=0 for 5 cycles in ISSUE, then int_wb_yumi_i delayed 3 cycles. Required: unit_v_o, op and operands stable for 6 cycles; wb data/rd stable; no new grant.
REQ-029 FSQRT: fp_is_sqrt_i=1, rs1=0x40800000, rs2=0xFFFFFFFF. Required: unit_op_o=3'b101, unit_b_o=0, fp_wb_v_o set with the unit result and int_wb_v_o=0.
REQ-030 Reset in BUSY: assert reset_i for 1 cycle. Required: all outputs 0 next cycle; a subsequent int request grants immediately (last_grant=FP); no spurious writeback.
REQ-031 Misdirected yumi: fp_wb_yumi_i pulsed during integer WB and in IDLE. Required: no state change; int_wb_v_o held until int_wb_yumi_i.
